// File: rtl/clk_div_multi.sv
// clk_div_multi: N-channel 50%-duty clock divider with shadowed half-period writes,
// per-channel enable and a global phase-align sync.
module clk_div_multi #(
    parameter int N_CH     = 2,
    parameter int CNT_W    = 32,
    parameter int SEL_W    = 1,
    parameter int DEF_HALF = 25_000_000
) (
    input  logic             I_CLK,
    input  logic             I_RST,
    input  logic [N_CH-1:0]  I_EN,
    input  logic             I_WE,
    input  logic [SEL_W-1:0] I_SEL,
    input  logic [CNT_W-1:0] I_HALF,
    input  logic             I_SYNC,
    output logic [N_CH-1:0]  O_CLK,
    output logic [N_CH-1:0]  O_TICK,
    output logic [N_CH-1:0]  O_PEND
);
    localparam logic [CNT_W-1:0] DEF = CNT_W'(DEF_HALF);

    logic [CNT_W-1:0] r_cnt [N_CH];
    logic [CNT_W-1:0] r_act [N_CH];
    logic [CNT_W-1:0] r_shd [N_CH];
    logic [N_CH-1:0]  r_clk, r_tick, r_pend;
    logic [N_CH-1:0]  w_wr, w_term, w_idle, w_bound;
    logic [CNT_W-1:0] w_half;

    always_comb begin
        w_half  = (I_HALF == '0) ? CNT_W'(1) : I_HALF;
        w_wr    = '0;
        w_term  = '0;
        w_idle  = '0;
        w_bound = '0;
        for (int c = 0; c < N_CH; c++) begin
            w_wr[c]    = I_WE && (I_SEL == SEL_W'(c));
            // >= keeps a shrunken active value from being skipped past
            w_term[c]  = r_cnt[c] >= r_act[c] - CNT_W'(1);
            w_idle[c]  = I_SYNC || !I_EN[c];
            w_bound[c] = w_idle[c] || w_term[c];
        end
    end

    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            for (int c = 0; c < N_CH; c++) begin
                r_cnt[c] <= '0;
                r_act[c] <= DEF;
                r_shd[c] <= DEF;
            end
            r_clk  <= '0;
            r_tick <= '0;
            r_pend <= '0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                r_cnt[c]  <= w_bound[c] ? '0 : r_cnt[c] + CNT_W'(1);
                if (w_bound[c] && r_pend[c])
                    r_act[c] <= r_shd[c];
                if (w_wr[c])
                    r_shd[c] <= w_half;
                r_pend[c] <= w_wr[c] || (r_pend[c] && !w_bound[c]);
                r_clk[c]  <= w_idle[c] ? 1'b0 : r_clk[c] ^ w_term[c];
                r_tick[c] <= !w_idle[c] && w_term[c] && !r_clk[c];
            end
        end
    end

    assign O_CLK  = r_clk;
    assign O_TICK = r_tick;
    assign O_PEND = r_pend;
endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
N-channel programmable clock divider, generalising the fixed-ratio, mode-selected divider. Each channel produces a 50 %-duty divided clock plus a one-cycle rising-edge tick. Each channel has its own runtime-loadable half-period and enable. Divisor changes are shadowed and applied only at a phase boundary, so the output never glitches. A global sync input phase-aligns all channels. The block feeds display scan, LED blink and debounce sampling logic.

Parameters:
N_CH, 2, number of independent divider channels (1..16)
CNT_W, 32, width of per-channel counter and half-period value
SEL_W, 1, width of channel-select bus (must satisfy 2**SEL_W >= N_CH)
DEF_HALF, 25_000_000, reset half-period in I_CLK cycles for every channel (1 Hz at 50 MHz)

Ports:
I_CLK  in  1  system clock; all logic on rising edge
I_RST  in  1  synchronous active-high reset
I_EN  in  N_CH  per-channel run enable
I_WE  in  1  half-period write strobe
I_SEL  in  SEL_W  target channel for write
I_HALF  in  CNT_W  new half-period value, in cycles
I_SYNC  in  1  global phase-align pulse
O_CLK  out  N_CH  divided clocks, registered
O_TICK  out  N_CH  one-cycle pulse in first high cycle of O_CLK, registered
O_PEND  out  N_CH  shadow half-period awaiting commit

Behaviour:
- Per-channel state: cnt[CNT_W], active[CNT_W], shadow[CNT_W], pend, O_CLK bit, O_TICK bit.
- Priority at each edge: I_RST > I_SYNC > per-channel I_EN.
- Reset (synchronous): cnt=0, O_CLK=0, O_TICK=0, O_PEND=0, active=shadow=DEF_HALF. Reset mid-operation discards any pending write.
- Write: if I_WE=1 and I_SEL<N_CH, then shadow[I_SEL] <= I_HALF and pend <= 1. I_HALF=0 is stored as 1. If I_SEL>=N_CH, the write is ignored and no state changes.
- Running (I_EN=1, no sync):
  - If cnt >= active-1 (terminal): O_CLK toggles and cnt <= 0. If pend=1, active <= shadow and pend <= 0.
  - Otherwise: cnt <= cnt+1.
  - The >= compare guards against an active value shrinking below the live count.
- Timing: output period = 2*active cycles, duty exactly 50 %. The first rising edge of O_CLK is registered on the active-th enabled edge after cnt=0.
- O_TICK=1 only in the cycle in which O_CLK has just become 1 (0->1 toggle). Otherwise O_TICK=0.
- Disabled (I_EN=0): cnt <= 0, O_CLK <= 0, O_TICK <= 0. A pending shadow commits immediately (active <= shadow, pend <= 0). Re-enable restarts from phase 0 with a low output.
- I_SYNC=1: every channel takes cnt=0, O_CLK=0, O_TICK=0 and commits any pending shadow, regardless of I_EN. A write in the same cycle still updates shadow and sets pend.
- Write coinciding with a terminal count on the same channel: the commit takes the shadow value held before the write. The write then sets shadow and pend=1, and the new value applies at the next boundary.
- Half-period changes never produce a phase shorter than min(old, new) cycles, and never produce a runt pulse.
- Channels are fully independent except for the shared write port and I_SYNC.

Test Plan:
- Reset, N_CH=2, DEF_HALF=4, I_EN=01 -> O_CLK[0] low 4 cycles then high 4 cycles, period 8. O_TICK[0] 1-cycle pulse every 8 cycles, coincident with each rising edge. O_CLK[1]=0 throughout.
- Write I_HALF=2 to ch0 during its 2nd high cycle -> O_PEND[0]=1. The high phase completes at 4 cycles, then phases of 2 cycles. O_PEND[0] clears on the falling-edge cycle.
- Write I_HALF=0 to ch1 while disabled, then enable -> O_PEND[1] clears the cycle after the write. O_CLK[1] toggles every cycle and O_TICK[1] pulses every 2 cycles.
- Ch0 half=3, ch1 half=5, both running mid-phase; pulse I_SYNC -> both outputs 0 next cycle. Rising edges occur 3 and 5 cycles after sync; periods are 6 and 10 thereafter.
- I_WE with I_SEL=3 (N_CH=2, SEL_W=2) -> no O_PEND change, no period change. Drop I_EN[0] mid high phase -> O_CLK[0]=0 the next cycle with no tick.
- Assert I_RST for 1 cycle mid-operation with a pending write on ch1 -> all O_* = 0. The pending write is lost and periods return to 2*DEF_HALF.
